// File: rtl/snr_pulse_driver.sv
// snr_pulse_driver
// Drives an active-low set/reset latch cell from a valid/ready command
// stream. Each command produces one registered, glitch-free low pulse on
// either lat_nset or lat_nrst, then a quiet gap with both drives high.
// After the gap, the synchronised latch readback is compared with the
// commanded value. The two drives can never be low together: both are
// decoded from one state and one stored command bit.

module snr_pulse_driver #(
   parameter int PULSE_W = 2,  // cycles the selected drive is held low (1..15)
   parameter int GAP_W   = 1   // cycles both drives are high before the check (1..15)
) (
   input  logic ck,
   input  logic nrst,
   input  logic cmd_valid,
   input  logic cmd_val,
   output logic cmd_ready,
   output logic lat_nset,
   output logic lat_nrst,
   input  logic lat_q,
   output logic busy,
   output logic done,
   output logic err
);

   // The 4-bit counter holds at most 14 (load value W-1), so out-of-range
   // widths are rejected at elaboration instead of wrapping silently.
   if (PULSE_W < 1 || PULSE_W > 15) begin : g_bad_pulse_w
      $error("snr_pulse_driver: PULSE_W must be in 1..15");
   end
   if (GAP_W < 1 || GAP_W > 15) begin : g_bad_gap_w
      $error("snr_pulse_driver: GAP_W must be in 1..15");
   end

   localparam logic [3:0] PULSE_LOAD = 4'(PULSE_W - 1);
   localparam logic [3:0] GAP_LOAD   = 4'(GAP_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PULSE = 2'd1,
      ST_GAP   = 2'd2,
      ST_CHECK = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       val_q, val_d;
   logic       nset_q, nset_d;
   logic       nrst_q, nrst_d;
   logic       sync1_q, q_s;

   // Next-state, counter and command-capture logic.
   always_comb begin
      // NOTE: every variable gets a default before the case, so no path
      // leaves one unassigned and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LOAD;
               val_d   = cmd_val;
            end
         end
         ST_PULSE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Drive levels for the next cycle, decoded from the next state so the
   // registered pulse lines up exactly with the PULSE state. Only one of
   // the two can be low because val_d picks exactly one of them.
   always_comb begin
      nset_d = !((state_d == ST_PULSE) && val_d);
      nrst_d = !((state_d == ST_PULSE) && !val_d);
   end

   // State, counter, stored command, drive registers and readback synchroniser.
   always_ff @(posedge ck) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      if (!nrst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         val_q   <= 1'b0;
         nset_q  <= 1'b1;
         nrst_q  <= 1'b1;
         sync1_q <= 1'b0;
         q_s     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         nset_q  <= nset_d;
         nrst_q  <= nrst_d;
         sync1_q <= lat_q;
         q_s     <= sync1_q;
      end
   end

   // Outputs: flop outputs or single-state decodes only, never a path from inputs.
   always_comb begin
      lat_nset  = nset_q;
      lat_nrst  = nrst_q;
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_CHECK);
      err       = (state_q == ST_CHECK) && (q_s != val_q);
   end

endmodule

// File: tb/tb_snr_pulse_driver.sv
// tb_snr_pulse_driver
// Directed bench: five driver instances with different PULSE_W/GAP_W, each
// attached to a behavioural set/reset latch. Expected waveforms come from
// the cycle timing of a command (pulse, gap, check, idle) worked out by hand.

module tb_snr_pulse_driver;

   localparam int N = 5;

   function automatic int pw_of(input int i);
      case (i)
         0:       return 2;
         1:       return 1;
         2:       return 15;
         3:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic int gw_of(input int i);
      case (i)
         0:       return 1;
         1:       return 1;
         2:       return 15;
         3:       return 15;
         default: return 1;
      endcase
   endfunction

   logic         ck = 1'b0;
   logic         nrst = 1'b0;
   logic         cmd_val = 1'b0;
   logic [N-1:0] cmd_valid = '0;
   logic [N-1:0] stuck = '0;
   wire  [N-1:0] ready, nset, nrs, busy, done, err, latq;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   always #5 ck = ~ck;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : g_dut
      logic mq = 1'b0;

      snr_pulse_driver #(
         .PULSE_W (pw_of(g)),
         .GAP_W   (gw_of(g))
      ) u_dut (
         .ck        (ck),
         .nrst      (nrst),
         .cmd_valid (cmd_valid[g]),
         .cmd_val   (cmd_val),
         .cmd_ready (ready[g]),
         .lat_nset  (nset[g]),
         .lat_nrst  (nrs[g]),
         .lat_q     (latq[g]),
         .busy      (busy[g]),
         .done      (done[g]),
         .err       (err[g])
      );

      // Behavioural latch: set dominates, otherwise holds its value.
      always @(nset[g] or nrs[g]) begin
         if (nset[g] === 1'b0) mq = 1'b1;
         else if (nrs[g] === 1'b0) mq = 1'b0;
      end

      assign latq[g] = stuck[g] ? 1'b0 : mq;
   end

   // Drives must never be low together on any instance.
   always @(negedge ck) begin
      if (mon_en) begin
         for (int i = 0; i < N; i++) begin
            check($sformatf("no_overlap[%0d]", i), 32'(!nset[i] && !nrs[i]), 32'd0);
         end
      end
   end

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   // One or two commands, starting with the DUT idle at the current sample
   // point (cycle 0). With two commands cmd_valid stays high, so the second
   // is accepted in the first ready cycle, L = PULSE_W+GAP_W+2.
   task automatic run_seq(input int idx, input int ncmd, input logic v1,
                          input logic v2, input logic exp_err);
      int   pw, gw, len, r;
      logic v;
      logic e_nset, e_nrs, e_done, e_busy;
      string t;
      pw  = pw_of(idx);
      gw  = gw_of(idx);
      len = pw + gw + 2;
      cmd_val        = v1;
      cmd_valid[idx] = 1'b1;
      check($sformatf("ready_c0[%0d]", idx), 32'(ready[idx]), 32'd1);
      for (int c = 1; c <= ncmd * len; c++) begin
         step();
         if (ncmd == 2 && c >= len) begin
            r = c - len;
            v = v2;
         end else begin
            r = c;
            v = v1;
         end
         e_nset = !(r >= 1 && r <= pw && v);
         e_nrs  = !(r >= 1 && r <= pw && !v);
         e_done = (r == pw + gw + 1);
         e_busy = (r >= 1 && r <= pw + gw + 1);
         t = $sformatf("[%0d] c%0d", idx, c);
         check({"nset", t},  32'(nset[idx]),  32'(e_nset));
         check({"nrst", t},  32'(nrs[idx]),   32'(e_nrs));
         check({"done", t},  32'(done[idx]),  32'(e_done));
         check({"err", t},   32'(err[idx]),   32'(e_done && exp_err));
         check({"busy", t},  32'(busy[idx]),  32'(e_busy));
         check({"ready", t}, 32'(ready[idx]), 32'(!e_busy));
         if (c == 1) begin
            cmd_val = v2;
            if (ncmd == 1) cmd_valid[idx] = 1'b0;
         end
         if (c == len + 1) cmd_valid[idx] = 1'b0;
      end
      cmd_valid[idx] = 1'b0;
   endtask

   initial begin
      // T1: reset held with a command pending, no pulse may appear.
      nrst         = 1'b0;
      cmd_valid[0] = 1'b1;
      cmd_val      = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("rst_nset", 32'(nset[0]), 32'd1);
         check("rst_nrst", 32'(nrs[0]),  32'd1);
         check("rst_busy", 32'(busy[0]), 32'd0);
         check("rst_done", 32'(done[0]), 32'd0);
         check("rst_err",  32'(err[0]),  32'd0);
      end
      mon_en    = 1'b1;
      cmd_valid = '0;
      nrst      = 1'b1;
      step();
      for (int i = 0; i < N; i++) begin
         check($sformatf("post_rst_ready[%0d]", i), 32'(ready[i]), 32'd1);
         check($sformatf("post_rst_busy[%0d]", i),  32'(busy[i]),  32'd0);
         check($sformatf("post_rst_nset[%0d]", i),  32'(nset[i]),  32'd1);
      end

      // T2: set with the latch attached.
      run_seq(0, 1, 1'b1, 1'b1, 1'b0);
      // Set again while already set: pulsed and checked normally.
      run_seq(0, 1, 1'b1, 1'b1, 1'b0);
      // T3: set then reset back-to-back.
      run_seq(0, 2, 1'b1, 1'b0, 1'b0);

      // T4: latch stuck at 0, set command must flag err with done.
      stuck[0] = 1'b1;
      repeat (3) step();
      run_seq(0, 1, 1'b1, 1'b1, 1'b1);
      stuck[0] = 1'b0;
      repeat (3) step();

      // T5: reset during PULSE drops the command.
      cmd_val      = 1'b1;
      cmd_valid[0] = 1'b1;
      step();
      cmd_valid[0] = 1'b0;
      check("t5_pulse_nset", 32'(nset[0]), 32'd0);
      check("t5_pulse_busy", 32'(busy[0]), 32'd1);
      nrst = 1'b0;
      step();
      check("t5_abort_nset",  32'(nset[0]),  32'd1);
      check("t5_abort_nrst",  32'(nrs[0]),   32'd1);
      check("t5_abort_busy",  32'(busy[0]),  32'd0);
      check("t5_abort_ready", 32'(ready[0]), 32'd1);
      nrst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         step();
         check("t5_no_done", 32'(done[0]), 32'd0);
         check("t5_no_err",  32'(err[0]),  32'd0);
         check("t5_idle",    32'(busy[0]), 32'd0);
      end
      run_seq(0, 1, 1'b0, 1'b0, 1'b0);

      // T6: width sweep over the extreme parameter corners.
      for (int i = 1; i < N; i++) begin
         run_seq(i, 1, 1'b1, 1'b1, 1'b0);
         run_seq(i, 1, 1'b0, 1'b0, 1'b0);
      end

      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
